// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - key debounce bus: raw keys and enable in, levels and strobes out
interface key_debounce_if;
   logic sw_add_raw;
   logic sw_sub_raw;
   logic en;
   logic sw_add;
   logic sw_sub;
   logic add_pulse;
   logic sub_pulse;
   logic conflict;

   modport master (
      output sw_add_raw, sw_sub_raw, en,
      input  sw_add, sw_sub, add_pulse, sub_pulse, conflict
   );

   modport slave (
      input  sw_add_raw, sw_sub_raw, en,
      output sw_add, sw_sub, add_pulse, sub_pulse, conflict
   );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-key debouncer with press strobes, auto-repeat and conflict detect
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 16
) (
   input logic clk,
   input logic rst_n,
   key_debounce_if.slave bus
);
   localparam int MAXP = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                         ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
                         : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam int W = $clog2(MAXP + 1);
   localparam logic [W-1:0] DB_LAST   = W'(DEBOUNCE_CYCLES - 1);
   localparam logic [W-1:0] RPT_DELAY = W'(REPEAT_DELAY);
   localparam logic [W-1:0] RPT_LAST  = W'(REPEAT_PERIOD - 1);
   localparam bit           RPT_EN    = (REPEAT_DELAY > 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_PRESSED,
      ST_RELEASE_WAIT
   } state_e;

   logic [1:0] raw;
   logic [1:0] level;
   logic [1:0] due;

   assign raw = {bus.sw_sub_raw, bus.sw_add_raw};

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic         sync1_q, sync2_q;
      state_e       state_q, state_d;
      logic [W-1:0] cnt_q, cnt_d, cnt_inc;
      logic [W-1:0] rpt_q, rpt_d;
      logic [W-1:0] per_q, per_d;
      logic         press_q, press_d;
      logic         level_q, level_d;
      logic         rpt_hit;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rpt_q   <= '0;
            per_q   <= '0;
            press_q <= 1'b0;
            level_q <= 1'b1;
         end else begin
            sync1_q <= raw[ch];
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            per_q   <= per_d;
            press_q <= press_d;
            level_q <= level_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         rpt_d   = rpt_q;
         per_d   = per_q;
         press_d = 1'b0;
         rpt_hit = 1'b0;
         cnt_inc = cnt_q + 1'b1;

         // Delay timer saturates at REPEAT_DELAY, then the period counter paces the repeats
         if (RPT_EN && (state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT)) begin
            if (rpt_q != RPT_DELAY) begin
               rpt_d = rpt_q + 1'b1;
            end else begin
               rpt_hit = (per_q == '0);
               per_d   = (per_q == RPT_LAST) ? '0 : per_q + 1'b1;
            end
         end

         unique case (state_q)
            ST_IDLE: begin
               if (!sync2_q) begin
                  state_d = ST_PRESS_WAIT;
                  cnt_d   = '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (sync2_q) begin
                  state_d = ST_IDLE;
               end else if (cnt_inc == DB_LAST) begin
                  state_d = ST_PRESSED;
                  press_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_PRESSED: begin
               if (sync2_q) begin
                  state_d = ST_RELEASE_WAIT;
                  cnt_d   = '0;
               end
            end
            ST_RELEASE_WAIT: begin
               if (!sync2_q) begin
                  state_d = ST_PRESSED;
               end else if (cnt_inc == DB_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (state_d == ST_IDLE) begin
            rpt_d = '0;
            per_d = '0;
         end
         level_d = (state_d == ST_IDLE) || (state_d == ST_PRESS_WAIT);
      end

      assign level[ch] = level_q;
      assign due[ch]   = press_q | rpt_hit;
   end

   logic add_pulse_q, sub_pulse_q, conflict_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_pulse_q <= 1'b0;
         sub_pulse_q <= 1'b0;
         conflict_q  <= 1'b0;
      end else begin
         add_pulse_q <= bus.en & due[0] & ~due[1];
         sub_pulse_q <= bus.en & due[1] & ~due[0];
         conflict_q  <= bus.en & due[0] & due[1];
      end
   end

   assign bus.sw_add    = level[0];
   assign bus.sw_sub    = level[1];
   assign bus.add_pulse = add_pulse_q;
   assign bus.sub_pulse = sub_pulse_q;
   assign bus.conflict  = conflict_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - table-driven and scoreboard bench for key_debounce
module tb_key_debounce;
   localparam int DB  = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;
   localparam int LAT = 2 + DB + 1;
   localparam logic [2:0] K_ADD  = 3'b001;
   localparam logic [2:0] K_SUB  = 3'b010;
   localparam logic [2:0] K_CONF = 3'b100;

   typedef struct {
      logic add;
      logic sub;
      int   hold;
      int   gap;
      int   exp_cnt;
      logic exp_lvl_add;
      logic exp_lvl_sub;
   } vec_t;

   typedef struct {
      int         cyc;
      logic [2:0] kind;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   int   seen = 0;
   int   unexpected = 0;
   bit   mon_on = 1'b0;
   logic [2:0] obs;
   exp_t sb[$];
   vec_t vecs[6];

   key_debounce_if bus();

   key_debounce #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Expected strobes: press after LAT, then repeats until the release is debounced
   task automatic expect_press(input logic [2:0] kind, input int f, input int r, input int min_t);
      if (f + LAT >= min_t) sb.push_back('{f + LAT, kind});
      for (int t = f + LAT + RD; t <= r + 2 + DB; t += RP)
         if (t >= min_t) sb.push_back('{t, kind});
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         obs = {bus.conflict, bus.sub_pulse, bus.add_pulse};
         if (obs != 3'b000) seen++;
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            check("strobe", int'(obs), int'(sb[0].kind));
            void'(sb.pop_front());
         end else if (obs != 3'b000) begin
            unexpected++;
            $display("unexpected strobe %b at cycle %0d", obs, cyc);
         end
      end
   end

   task automatic run_vec(input vec_t v, input int idx);
      int f;
      logic [2:0] kind;
      kind = (v.add && v.sub) ? K_CONF : (v.add ? K_ADD : K_SUB);
      @(posedge clk); #1;
      bus.sw_add_raw = ~v.add;
      bus.sw_sub_raw = ~v.sub;
      f = cyc;
      seen = 0;
      if (v.hold >= DB) expect_press(kind, f, f + v.hold, f);
      for (int i = 1; i <= v.hold + v.gap; i++) begin
         @(posedge clk); #1;
         if (i == v.hold) begin
            bus.sw_add_raw = 1'b1;
            bus.sw_sub_raw = 1'b1;
         end
         if (i == LAT) begin
            check($sformatf("vec%0d_sw_add", idx), int'(bus.sw_add), int'(v.exp_lvl_add));
            check($sformatf("vec%0d_sw_sub", idx), int'(bus.sw_sub), int'(v.exp_lvl_sub));
         end
      end
      check($sformatf("vec%0d_count", idx), seen, v.exp_cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int f, q;
      vecs[0] = '{1'b1, 1'b0, 20, 10, 5, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b1,  3, 10, 0, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 1'b1,  4, 10, 1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 30, 10, 8, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 1'b1,  8, 10, 1, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 1'b1,  8, 10, 1, 1'b1, 1'b0};

      bus.sw_add_raw = 1'b1;
      bus.sw_sub_raw = 1'b1;
      bus.en = 1'b1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 check("reset_outs", int'({bus.sw_add, bus.sw_sub, bus.add_pulse, bus.sub_pulse, bus.conflict}), 5'b11000);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      mon_on = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Bounce on sub: six single-cycle toggles, then a clean fall
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         bus.sw_sub_raw = (i % 2 == 1);
      end
      @(posedge clk); #1;
      bus.sw_sub_raw = 1'b0;
      f = cyc;
      expect_press(K_SUB, f, f + 8, f);
      for (int i = 1; i <= 18; i++) begin
         @(posedge clk); #1;
         if (i == 8) bus.sw_sub_raw = 1'b1;
      end
      check("bounce_count", seen, 1);

      // Enable low through the press point, back high before the first repeat
      seen = 0;
      @(posedge clk); #1;
      bus.en = 1'b0;
      bus.sw_add_raw = 1'b0;
      f = cyc;
      expect_press(K_ADD, f, f + 20, f + 13);
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         if (i == 10) begin
            check("en0_sw_add", int'(bus.sw_add), 0);
            check("en0_no_pulse", int'(bus.add_pulse), 0);
         end
         if (i == 12) bus.en = 1'b1;
         if (i == 20) bus.sw_add_raw = 1'b1;
      end
      check("en_count", seen, 4);

      // Reset asserted during a repeat strobe while the key stays held
      @(posedge clk); #1;
      bus.sw_add_raw = 1'b0;
      f = cyc;
      sb.push_back('{f + LAT, K_ADD});
      for (int i = 1; i <= LAT + RD; i++) @(posedge clk);
      #2 check("pre_reset_repeat", int'(bus.add_pulse), 1);
      rst_n = 1'b0;
      #1 check("mid_reset_outs", int'({bus.sw_add, bus.sw_sub, bus.add_pulse, bus.sub_pulse, bus.conflict}), 5'b11000);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      q = cyc;
      seen = 0;
      expect_press(K_ADD, q, q + 8, q);
      for (int i = 1; i <= 18; i++) begin
         @(posedge clk); #1;
         if (i == 8) bus.sw_add_raw = 1'b1;
      end
      check("post_reset_count", seen, 1);

      check("sb_empty", sb.size(), 0);
      check("no_unexpected", unexpected, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized samples needed to accept a level change (min 2).
REQ-002 Parameter REPEAT_DELAY, default 64, cycles held in PRESSED before auto-repeat starts (0 disables auto-repeat).
REQ-003 Parameter REPEAT_PERIOD, default 16, cycles between auto-repeat pulses (min 1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sw_add_raw  input  1  raw add key, active-low, asynchronous, bouncing.
REQ-007 sw_sub_raw  input  1  raw sub key, active-low, asynchronous, bouncing.
REQ-008 en  input  1  pulse enable; high = pulses allowed.
REQ-009 sw_add  output  1  debounced add level, active-low; feeds the counter's sw_add.
REQ-010 sw_sub  output  1  debounced sub level, active-low; feeds the counter's sw_sub.
REQ-011 add_pulse  output  1  one-cycle high strobe per accepted add press or repeat.
REQ-012 sub_pulse  output  1  one-cycle high strobe per accepted sub press or repeat.
REQ-013 conflict  output  1  one-cycle high when add and sub strobes coincide.

Function
REQ-014 Each raw input passes a 2-flop synchronizer; the sampled value is the 2nd flop output.
REQ-015 Each channel has an independent FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-016 IDLE: sampled 0 -> PRESS_WAIT with stability counter cleared; else stay.
REQ-017 PRESS_WAIT: sampled 1 -> IDLE (glitch rejected); counter reaching DEBOUNCE_CYCLES-1 with sampled 0 -> PRESSED.
REQ-018 PRESSED: sampled 1 -> RELEASE_WAIT with counter cleared; else stay, running the repeat timer.
REQ-019 RELEASE_WAIT: sampled 0 -> PRESSED (repeat timer not reset); counter reaching DEBOUNCE_CYCLES-1 with sampled 1 -> IDLE.
REQ-020 Debounced level is 0 in PRESSED and RELEASE_WAIT, 1 in IDLE and PRESS_WAIT; registered output.
REQ-021 Press strobe asserts exactly in the cycle after the PRESS_WAIT->PRESSED transition; latency raw fall -> strobe = 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-022 Auto-repeat: with REPEAT_DELAY>0, strobe again when PRESSED time reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles while PRESSED/RELEASE_WAIT.
REQ-023 Repeat timer saturates its width and clears on entry to IDLE; no wrap-around strobes.
REQ-024 en=0: add_pulse, sub_pulse, conflict forced 0; FSMs, levels, and timers keep running; strobes are dropped, not queued.
REQ-025 Both channel strobes due in same cycle: add_pulse=0, sub_pulse=0, conflict=1 for that cycle (if en=1).
REQ-026 Counter widths are $clog2 of max parameter value + 1; no truncation for any legal parameter.

Reset
REQ-027 rst_n low at any time (including mid-debounce or mid-repeat) asynchronously forces: FSMs IDLE, synchronizer flops 1, counters 0, sw_add=sw_sub=1, all strobes 0.
REQ-028 After rst_n rises, a key already held low is treated as a new press and is debounced fully before any strobe.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 Clean press: sw_add_raw 1->0 held 20 cycles -> sw_add 0 and one add_pulse 7 cycles after the edge, no further pulse before the REPEAT_DELAY point.
REQ-030 Bounce: sw_sub_raw toggles every cycle for 6 cycles, then held 0 -> no sub_pulse during the toggling; exactly one sub_pulse 7 cycles after the final fall.
REQ-031 Auto-repeat: sw_add_raw held 0 for 30 cycles -> add_pulse at press, at +10, then every 3 cycles; stops within DEBOUNCE_CYCLES+2 cycles of release.
REQ-032 Simultaneous press of both keys on the same edge -> conflict=1 for one cycle, add_pulse=sub_pulse=0, both levels 0.
REQ-033 en=0 during a press -> no strobes, sw_add still 0; en back to 1 while held -> next strobe only at the next repeat point.
REQ-034 rst_n pulsed low mid-repeat -> all outputs reset immediately; key still held after release of reset -> new press strobe 7 cycles later.
